dense1_bias_requant_relu6: RTL and testbench



---
 rtl/dense1_bias_requant_relu6_pkg.sv | 17 +
 rtl/dense1_bias_requant_relu6_requant_relu6.sv | 38 +++
 rtl/dense1_bias_requant_relu6.sv | 139 +++++++++++++
 tb/tb_dense1_bias_requant_relu6.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dense1_bias_requant_relu6_pkg.sv
// Shared CNN constants and the sequencing state type for the dense stages.
package dense1_bias_requant_relu6_pkg;

    // Activations are Q3.5, so 6.0 is 6 << 5 = 192.
    localparam int ACT_FRAC           = 5;
    localparam int RELU6_MAX_Q35      = 6 << ACT_FRAC;
    localparam int DENSE1_NUM_NEURONS = 128;
    localparam int IDX_W              = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/dense1_bias_requant_relu6_requant_relu6.sv
// Combinational requantizer: round half toward +inf, arithmetic shift,
// then clamp into [0, RELU6_MAX]. Shared with later dense stages.
module requant_relu6
    import dense1_bias_requant_relu6_pkg::*;
#(
    parameter int IN_W      = 33,
    parameter int OUT_SHIFT = 8,
    parameter int RELU6_MAX = RELU6_MAX_Q35,
    parameter int OUT_W     = 8
) (
    input  logic signed [IN_W-1:0]  din,
    output logic        [OUT_W-1:0] dout
);

    // One guard bit so adding the rounding constant can never wrap.
    localparam int W = IN_W + 1;
    localparam logic signed [W-1:0] HALF = {{(W-1){1'b0}}, 1'b1} << (OUT_SHIFT - 1);
    localparam logic signed [W-1:0] MAXV = W'(RELU6_MAX);

    logic signed [W-1:0] din_ext;
    logic signed [W-1:0] rounded;
    logic signed [W-1:0] r;

    // Round, shift and clamp in one combinational step.
    always_comb begin
        din_ext = {din[IN_W-1], din};
        rounded = din_ext + HALF;
        r       = rounded >>> OUT_SHIFT;
        if (r < 0) begin
            dout = '0;
        end else if (r > MAXV) begin
            dout = MAXV[OUT_W-1:0];
        end else begin
            dout = r[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/dense1_bias_requant_relu6.sv
// Dense-1 post-accumulation stage: bias add, requantize, ReLU6.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | accepting accumulators 0..NUM_NEURONS-1
// DRAIN | all accepted, flushing pipeline until out_last handshakes
// DONE  | one-cycle done pulse, then back to IDLE
module dense1_bias_requant_relu6
    import dense1_bias_requant_relu6_pkg::*;
#(
    parameter int NUM_NEURONS = DENSE1_NUM_NEURONS,
    parameter int ACC_W       = 24,
    parameter int BIAS_SHIFT  = 8,
    parameter int OUT_SHIFT   = 8,
    parameter int RELU6_MAX   = RELU6_MAX_Q35
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic             acc_valid,
    output logic             acc_ready,
    input  logic [ACC_W-1:0] acc_data,
    output logic [7:0]       bias_addr,
    input  logic [7:0]       bias_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [6:0]       out_idx,
    output logic             out_last
);

    // Nine extra bits cover the 8-bit bias shifted by BIAS_SHIFT plus carry.
    localparam int SUM_W = ACC_W + 9;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    state_t state;
    state_t state_next;

    logic [IDX_W-1:0]        idx_cnt;
    logic                    accept;
    logic                    s1_adv;
    logic                    s1_valid;
    logic                    s2_valid;
    logic signed [SUM_W-1:0] s1_sum;
    logic [IDX_W-1:0]        s1_idx;
    logic signed [SUM_W-1:0] acc_ext;
    logic signed [SUM_W-1:0] bias_ext;
    logic signed [SUM_W-1:0] sum_next;
    logic [7:0]              rq_out;

    assign s1_adv    = !s2_valid || out_ready;
    assign acc_ready = (state == RUN) && (!s1_valid || s1_adv);
    assign accept    = acc_valid && acc_ready;
    assign bias_addr = 8'(idx_cnt);
    assign busy      = (state == RUN) || (state == DRAIN);
    assign done      = (state == DONE);
    assign out_valid = s2_valid;

    assign acc_ext  = {{(SUM_W-ACC_W){acc_data[ACC_W-1]}}, acc_data};
    assign bias_ext = {{(SUM_W-8){bias_data[7]}}, bias_data};
    assign sum_next = acc_ext + (bias_ext <<< BIAS_SHIFT);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start only matters in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (accept && (idx_cnt == LAST_IDX)) state_next = DRAIN;
            DRAIN:   if (s2_valid && out_ready && out_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Neuron index: cleared on start, advanced on every accepted accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_cnt <= '0;
        end else if ((state == IDLE) && start) begin
            idx_cnt <= '0;
        end else if (accept) begin
            idx_cnt <= (idx_cnt == LAST_IDX) ? '0 : idx_cnt + 1'b1;
        end
    end

    // Stage 1: bias-aligned sum, loaded whenever the stage is free to move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_idx   <= '0;
        end else if (!s1_valid || s1_adv) begin
            s1_valid <= accept;
            if (accept) begin
                s1_sum <= sum_next;
                s1_idx <= idx_cnt;
            end
        end
    end

    requant_relu6 #(
        .IN_W      (SUM_W),
        .OUT_SHIFT (OUT_SHIFT),
        .RELU6_MAX (RELU6_MAX),
        .OUT_W     (8)
    ) u_requant (
        .din  (s1_sum),
        .dout (rq_out)
    );

    // Stage 2: output register, held while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out_data <= '0;
            out_idx  <= '0;
            out_last <= 1'b0;
        end else if (s1_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= rq_out;
                out_idx  <= s1_idx;
                out_last <= (s1_idx == LAST_IDX);
            end
        end
    end

endmodule

// File: tb/tb_dense1_bias_requant_relu6.sv
// Randomized bench for dense1_bias_requant_relu6 with a behavioural model.
module tb_dense1_bias_requant_relu6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic        acc_valid;
    logic        acc_ready;
    logic [23:0] acc_data;
    logic [7:0]  bias_addr;
    logic [7:0]  bias_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [6:0]  out_idx;
    logic        out_last;

    always #5 clk = ~clk;

    logic [7:0]  bias_rom [128];
    logic [23:0] acc_tab  [128];

    assign bias_data = bias_rom[bias_addr[6:0]];

    dense1_bias_requant_relu6 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .acc_valid (acc_valid),
        .acc_ready (acc_ready),
        .acc_data  (acc_data),
        .bias_addr (bias_addr),
        .bias_data (bias_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: exact rounding of (acc + bias*256)/256 half toward +inf, then ReLU6.
    function automatic int model(input int acc, input int bias);
        longint s, t, r;
        s = longint'(acc) + longint'(bias) * 256;
        t = s + 128;
        if (t >= 0) r = t / 256;
        else        r = -((-t + 255) / 256);
        if (r < 0)   return 0;
        if (r > 192) return 192;
        return int'(r);
    endfunction

    typedef struct {
        int exp_data;
        int exp_idx;
        bit exp_last;
        int stamp;
    } beat_t;

    beat_t q[$];
    int    m_idx = 0;
    int    m_cnt = 0;
    int    cyc = 0;
    bit    lat_mode = 0;
    int    out_cnt = 0;
    int    last_cnt = 0;
    int    done_cnt = 0;
    int    stall_seen = 0;
    int    cap [128];
    bit    prev_stall = 0;
    bit    prev_done = 0;
    logic [7:0] prev_d;
    logic [6:0] prev_i;
    logic       prev_l;

    // Compare process: sample everything at the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_idx      = 0;
            m_cnt      = 0;
            prev_stall = 0;
            prev_done  = 0;
        end else begin
            bit    in_run;
            bit    exp_rdy;
            beat_t b;
            cyc++;
            if (start && !busy && !done) m_cnt = 0;
            in_run  = busy && (m_cnt < 128);
            exp_rdy = in_run && ((q.size() < 2) || out_ready);
            chk(acc_ready == exp_rdy, "acc_ready", acc_ready, exp_rdy);
            chk(bias_addr == 8'(m_idx), "bias_addr", bias_addr, m_idx);
            if (busy && !acc_ready && in_run) stall_seen++;
            if (prev_stall) begin
                chk(out_valid && out_data == prev_d && out_idx == prev_i && out_last == prev_l,
                    "stable", {out_valid, out_last, out_idx, out_data}, {1'b1, prev_l, prev_i, prev_d});
            end
            if (acc_valid && acc_ready) begin
                b.exp_data = model($signed(acc_data), $signed(bias_rom[m_idx]));
                b.exp_idx  = m_idx;
                b.exp_last = (m_idx == 127);
                b.stamp    = cyc;
                q.push_back(b);
                m_idx = (m_idx + 1) % 128;
                m_cnt++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk(1'b0, "unexpected_out", out_idx, -1);
                end else begin
                    b = q.pop_front();
                    chk(out_data == 8'(b.exp_data), "out_data", out_data, b.exp_data);
                    chk(out_idx == 7'(b.exp_idx), "out_idx", out_idx, b.exp_idx);
                    chk(out_last == b.exp_last, "out_last", out_last, b.exp_last);
                    if (lat_mode) chk(cyc - b.stamp == 2, "latency", cyc - b.stamp, 2);
                    cap[out_idx] = out_data;
                end
                out_cnt++;
                if (out_last) last_cnt++;
            end
            if (done) begin
                done_cnt++;
                chk(!prev_done, "done_width", 2, 1);
            end
            prev_done  = done;
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
            prev_i     = out_idx;
            prev_l     = out_last;
        end
    end

    task automatic do_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // One pass; glitch_at pulses start mid-run, abort_at resets mid-run (-1 = off).
    task automatic run_pass(input bit rnd, input int glitch_at, input int abort_at);
        int drv;
        int budget;
        bit fire;
        bit glitched;
        drv = 0; glitched = 0;
        out_cnt = 0; last_cnt = 0; done_cnt = 0;
        lat_mode = !rnd;
        do_start();
        acc_valid = rnd ? 1'($urandom) : 1'b1;
        acc_data  = acc_tab[0];
        out_ready = rnd ? 1'($urandom) : 1'b1;
        budget = 0;
        while (drv < 128 && budget < 3000) begin
            @(negedge clk);
            fire = acc_valid && acc_ready;
            @(posedge clk); #1;
            if (fire) drv++;
            budget++;
            if (abort_at >= 0 && drv == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk({out_valid, out_data, out_idx, out_last, busy, done, acc_ready, bias_addr} == '0,
                    "reset_outputs", {out_valid, out_data, out_idx, out_last, busy, done, acc_ready}, 0);
                acc_valid = 1'b0;
                out_ready = 1'b1;
                start     = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                repeat (10) @(posedge clk);
                #1;
                chk(done_cnt == 0, "no_done_after_abort", done_cnt, 0);
                chk(busy == 1'b0, "idle_after_abort", busy, 0);
                return;
            end
            if (glitch_at >= 0 && drv == glitch_at && !glitched) begin
                start = 1'b1; glitched = 1'b1;
            end else begin
                start = 1'b0;
            end
            acc_valid = (drv < 128) ? (rnd ? 1'($urandom) : 1'b1) : 1'b0;
            acc_data  = acc_tab[(drv < 128) ? drv : 0];
            out_ready = rnd ? 1'($urandom) : 1'b1;
        end
        chk(drv == 128, "accept_budget", drv, 128);
        start = 1'b0;
        budget = 0;
        while (done_cnt == 0 && budget < 2000) begin
            @(posedge clk); #1;
            out_ready = rnd ? 1'($urandom) : 1'b1;
            budget++;
        end
        chk(done_cnt > 0, "done_timeout", done_cnt, 1);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk(done_cnt == 1, "done_count", done_cnt, 1);
        chk(out_cnt == 128, "out_count", out_cnt, 128);
        chk(last_cnt == 1, "last_count", last_cnt, 1);
        chk(q.size() == 0, "queue_empty", q.size(), 0);
    endtask

    task automatic fill_acc_random();
        for (int i = 0; i < 128; i++) begin
            if ($urandom % 2) acc_tab[i] = 24'($urandom_range(0, 98304)) - 24'd40000;
            else              acc_tab[i] = 24'($urandom);
        end
    endtask

    int round_acc [4];
    int round_exp [4];

    initial begin
        rst_n = 1'b0; start = 1'b0; acc_valid = 1'b0; out_ready = 1'b0; acc_data = '0;
        for (int i = 0; i < 128; i++) bias_rom[i] = 8'($urandom);
        bias_rom[0]  = 8'h36;
        bias_rom[3]  = 8'h70;
        bias_rom[7]  = 8'hff;
        bias_rom[47] = 8'h00;
        #12;
        chk({out_valid, out_data, out_idx, out_last, busy, done, acc_ready, bias_addr} == '0,
            "reset_state", {out_valid, out_data, out_idx, out_last, busy, done}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Zero accumulators: output is the clamped bias.
        for (int i = 0; i < 128; i++) acc_tab[i] = '0;
        run_pass(1'b0, -1, -1);
        chk(cap[0] == 54, "bias_idx0", cap[0], 54);
        chk(cap[7] == 0, "bias_idx7", cap[7], 0);
        chk(cap[3] == 112, "bias_idx3", cap[3], 112);

        // Saturation both ways.
        fill_acc_random();
        acc_tab[3] = 24'd100 << 8;
        acc_tab[0] = 24'hC00000;
        run_pass(1'b0, -1, -1);
        chk(cap[3] == 192, "sat_high", cap[3], 192);
        chk(cap[0] == 0, "sat_low", cap[0], 0);

        // Rounding around the half point at a zero-bias neuron.
        round_acc = '{128, 127, -128, -129};
        round_exp = '{1, 0, 0, 0};
        for (int k = 0; k < 4; k++) begin
            fill_acc_random();
            acc_tab[47] = 24'(round_acc[k]);
            run_pass(1'b0, -1, -1);
            chk(cap[47] == round_exp[k], "round_idx47", cap[47], round_exp[k]);
        end

        // Random backpressure and bursty valid.
        stall_seen = 0;
        for (int k = 0; k < 3; k++) begin
            fill_acc_random();
            run_pass(1'b1, -1, -1);
        end
        chk(stall_seen > 0, "acc_ready_drops", stall_seen, 1);

        // acc_valid in IDLE is not accepted.
        @(posedge clk); #1 acc_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk(acc_ready == 1'b0, "idle_no_accept", acc_ready, 0);
        end
        @(posedge clk); #1 acc_valid = 1'b0;

        // start during RUN is ignored.
        fill_acc_random();
        run_pass(1'b1, 30, -1);

        // Reset mid-pass, then a clean pass from index 0.
        fill_acc_random();
        run_pass(1'b1, -1, 60);
        fill_acc_random();
        run_pass(1'b1, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
